// File: rtl/mem_pkg.sv
// Shared types and constants for the LC-3 memory responder.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } mem_state_t;

  localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;
  localparam int          WAIT_W          = 4;

endpackage

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: services CPU requests on an async SRAM
// with programmable wait states, or on the memory-mapped switch/hex I/O word.
module mem_responder
  import mem_pkg::*;
#(
  parameter int          WAIT_STATES = 1,
  parameter logic [15:0] IO_ADDR     = IO_ADDR_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        MEM_REQ,
  input  logic        MEM_WE,
  input  logic [15:0] MEM_ADDR,
  input  logic [15:0] MEM_WDATA,
  output logic [15:0] MEM_RDATA,
  output logic        MEM_READY,
  input  logic [15:0] SW,
  output logic [15:0] HEX_OUT,
  output logic [15:0] SRAM_ADDR,
  input  logic [15:0] SRAM_DQ_IN,
  output logic [15:0] SRAM_DQ_OUT,
  output logic        SRAM_DQ_OE,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N
);

  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_STATES);

  mem_state_t        state, state_nxt;
  logic [WAIT_W-1:0] cnt, cnt_nxt;
  logic              we_q, we_nxt;
  logic [15:0]       rdata_nxt, hex_nxt, addr_nxt, dq_out_nxt;
  logic              ready_nxt, dq_oe_nxt, ce_n_nxt, oe_n_nxt, we_n_nxt;

  // Every output is computed one cycle ahead so the pins come straight off flops.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    we_nxt     = we_q;
    ready_nxt  = 1'b0;
    rdata_nxt  = MEM_RDATA;
    hex_nxt    = HEX_OUT;
    addr_nxt   = SRAM_ADDR;
    dq_out_nxt = SRAM_DQ_OUT;
    dq_oe_nxt  = SRAM_DQ_OE;
    ce_n_nxt   = SRAM_CE_N;
    oe_n_nxt   = SRAM_OE_N;
    we_n_nxt   = SRAM_WE_N;
    case (state)
      IDLE: begin
        if (MEM_REQ) begin
          we_nxt = MEM_WE;
          if (MEM_ADDR == IO_ADDR) begin
            state_nxt = DONE;
            ready_nxt = 1'b1;
            if (MEM_WE) hex_nxt   = MEM_WDATA;
            else        rdata_nxt = SW;
          end else begin
            state_nxt = SETUP;
            addr_nxt  = MEM_ADDR;
            ce_n_nxt  = 1'b0;
            if (MEM_WE) begin
              dq_out_nxt = MEM_WDATA;
              dq_oe_nxt  = 1'b1;
            end else begin
              oe_n_nxt = 1'b0;
            end
          end
        end
      end
      SETUP: begin
        cnt_nxt   = WAIT_INIT;
        state_nxt = ACCESS;
        if (we_q) we_n_nxt = 1'b0;
      end
      ACCESS: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          state_nxt = DONE;
          ready_nxt = 1'b1;
          ce_n_nxt  = 1'b1;
          oe_n_nxt  = 1'b1;
          we_n_nxt  = 1'b1;
          if (!we_q) rdata_nxt = SRAM_DQ_IN;
        end
      end
      DONE: begin
        // Write data is held through DONE, after WE_N has already risen.
        state_nxt = IDLE;
        dq_oe_nxt = 1'b0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      we_q        <= 1'b0;
      MEM_READY   <= 1'b0;
      MEM_RDATA   <= '0;
      HEX_OUT     <= '0;
      SRAM_ADDR   <= '0;
      SRAM_DQ_OUT <= '0;
      SRAM_DQ_OE  <= 1'b0;
      SRAM_CE_N   <= 1'b1;
      SRAM_OE_N   <= 1'b1;
      SRAM_WE_N   <= 1'b1;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      we_q        <= we_nxt;
      MEM_READY   <= ready_nxt;
      MEM_RDATA   <= rdata_nxt;
      HEX_OUT     <= hex_nxt;
      SRAM_ADDR   <= addr_nxt;
      SRAM_DQ_OUT <= dq_out_nxt;
      SRAM_DQ_OE  <= dq_oe_nxt;
      SRAM_CE_N   <= ce_n_nxt;
      SRAM_OE_N   <= oe_n_nxt;
      SRAM_WE_N   <= we_n_nxt;
    end
  end

endmodule
